mem_bank_param: RTL and testbench
=================================

# mem_bank_param

Parametrised single-port synchronous memory bank: the generalised successor of the fixed 8-line × 8-bit chip-selected memory. Width and depth are parameters, and the read port is registered with a one-cycle `data_valid` strobe. Same-cycle read/write is write-first. A hardware clear sequencer zeroes every line, one line per cycle, while flagging `busy`. The block sits behind the address decode / chip-select level of the design and serves as the storage element for register-file and scratchpad users.

## Interface
- `WIDTH`, default 8: bits per line; valid range ≥1.
- `DEPTH`, default 8: number of lines; must be a power of two, ≥2.
- `ADDR_W`, default 3: address width; must equal log2(`DEPTH`).

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `chip_select` in 1: qualifies `read_en`, `write_en` and `clear_start`; when low, all three are ignored.
- `address` in `ADDR_W`: line index for read and write.
- `data_in` in `WIDTH`: write data.
- `read_en` in 1: read request.
- `write_en` in 1: write request.
- `clear_start` in 1: starts the clear sweep.
- `data_out` out `WIDTH`: registered read data; holds its value between reads.
- `data_valid` out 1: one-cycle pulse, aligned with new `data_out`.
- `busy` out 1: high while the clear sweep runs.
- `access_err` out 1: one-cycle pulse when a read or write is requested during the clear sweep.

## Operation
- State machine states:
  - IDLE: normal access.
  - CLEAR: sweep.
- Write (IDLE, `chip_select` && `write_en`): `mem[address]` ← `data_in` at the edge.
- Read (IDLE, `chip_select` && `read_en`): at the edge, `data_out` ← `mem[address]` and `data_valid` ← 1.
  - With no read that cycle, `data_valid` ← 0 and `data_out` is unchanged.
- Simultaneous read + write:
  - Both are performed.
  - If read and write target the same line, `data_out` returns `data_in` (write-first).
  - Other lines behave normally; with a single address port the address is shared, so read and write always target the same line.
- Clear sweep:
  - IDLE with `chip_select` && `clear_start` → CLEAR. The line counter loads 0.
  - A read or write presented in that same cycle is still performed first.
  - In CLEAR, each cycle:
    - `mem[counter]` ← 0 and the counter increments.
    - After writing line `DEPTH-1`, the state returns to IDLE.
    - The counter is `ADDR_W` bits wide and wraps to 0; it is not used outside CLEAR.
- Requests during CLEAR:
  - Any `chip_select` && (`read_en` || `write_en`) is dropped: memory is untouched, `data_out` is unchanged, `data_valid` stays 0.
  - `access_err` pulses 1 on the next cycle.
  - `clear_start` during CLEAR is ignored and raises no error.
- Reset:
  - Effects:
    - All lines ← 0.
    - `data_out` ← 0.
    - `data_valid`, `busy` and `access_err` ← 0.
    - State ← IDLE; counter ← 0.
  - Reset takes priority over every other input, including in the middle of a sweep: the sweep aborts and the state is IDLE on the next cycle.

## Timing
- Write latency: data is visible to a read issued on the following cycle.
- Read latency: 1 cycle, from the request edge to `data_out`/`data_valid`.
- Back-to-back reads: one result per cycle; `data_valid` stays high continuously.
- `busy` timing:
  - Rises on the edge after `clear_start` is accepted.
  - Stays high exactly `DEPTH` cycles.
  - Falls on the edge that completes line `DEPTH-1`.
  - An access in the first cycle with `busy` low is accepted normally.
- `access_err` timing: asserted in the cycle after the rejected request, exactly one cycle per rejected request; consecutive rejected requests keep it high.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then write 0xA5 to line 3 and 0x5A to line 7; read lines 3, 7, 0 back-to-back.
  - Required: `data_out` = 0xA5, 0x5A, 0x00 on consecutive cycles, with `data_valid` high for 3 cycles then low.
- Same-cycle read + write to line 2 with `data_in` = 0x3C, where line 2 previously held 0x11.
  - Required: `data_out` = 0x3C next cycle, and a later read of line 2 returns 0x3C.
- With `chip_select` low, assert write 0xFF to line 1 and assert read.
  - Required: no `data_valid`, and a later read of line 1 returns its prior value.
- Fill all 8 lines with nonzero values, pulse `clear_start`, then read line 4 during the sweep.
  - Required: `busy` high exactly 8 cycles, `access_err` pulses once, and `data_out` is unchanged.
  - Required after `busy` falls: every line reads 0x00.
- Assert `reset` in the 4th cycle of a sweep.
  - Required: next cycle `busy` = 0, state IDLE, `data_out` = 0, and all lines read 0x00.
- Parameter sweep WIDTH=16, DEPTH=32, ADDR_W=5: write 0xBEEF to line 31, then wrap the address to line 0 and write 0x1234.
  - Required: both values read back correctly.
  - Required: the clear sweep holds `busy` high for 32 cycles.

Source files
------------

// File: rtl/mem_bank_param.sv
// Parametrised single-port synchronous memory bank.
// Registered, write-first read port and a one-line-per-cycle clear sweep.
module mem_bank_param #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              chip_select,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              read_en,
  input  logic              write_en,
  input  logic              clear_start,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              access_err
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] cnt_q;
  logic [WIDTH-1:0]  dout_q;
  logic              valid_q;
  logic              busy_q;
  logic              err_q;

  logic              acc_ok_d;
  logic              do_wr_d;
  logic              do_rd_d;
  logic              start_d;
  logic              rej_d;
  logic [WIDTH-1:0]  rdata_d;

  always_comb begin
    acc_ok_d = (state_q == IDLE) && chip_select;
    do_wr_d  = acc_ok_d && write_en;
    do_rd_d  = acc_ok_d && read_en;
    start_d  = acc_ok_d && clear_start;
    rej_d    = (state_q == CLEAR) && chip_select
               && (read_en || write_en);
    // address is shared, so a concurrent write always hits the read line
    rdata_d  = write_en ? data_in : mem_q[address];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= do_rd_d;
      err_q   <= rej_d;
      if (do_rd_d) begin
        dout_q <= rdata_d;
      end
      unique case (state_q)
        IDLE: begin
          if (do_wr_d) begin
            mem_q[address] <= data_in;
          end
          if (start_d) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          mem_q[cnt_q] <= '0;
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign access_err = err_q;

endmodule

// File: tb/tb_mem_bank_param.sv
// Scoreboard bench for mem_bank_param: an 8x8 and a 16x32 bank
// driven in lockstep against an array/queue reference model.
module tb_mem_bank_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cs, re, we, clr;
  logic [4:0]  addr;
  logic [15:0] din;

  logic [7:0]  a_dout;
  logic        a_valid, a_busy, a_err;
  logic [15:0] b_dout;
  logic        b_valid, b_busy, b_err;

  mem_bank_param #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut_a (
    .clock(clk), .reset(rst), .chip_select(cs),
    .address(addr[2:0]), .data_in(din[7:0]),
    .read_en(re), .write_en(we), .clear_start(clr),
    .data_out(a_dout), .data_valid(a_valid),
    .busy(a_busy), .access_err(a_err)
  );

  mem_bank_param #(.WIDTH(16), .DEPTH(32), .ADDR_W(5)) dut_b (
    .clock(clk), .reset(rst), .chip_select(cs),
    .address(addr), .data_in(din),
    .read_en(re), .write_en(we), .clear_start(clr),
    .data_out(b_dout), .data_valid(b_valid),
    .busy(b_busy), .access_err(b_err)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mm [2][32];
  int          left [2];
  int          dep [2] = '{8, 32};
  logic [15:0] msk [2] = '{16'h00FF, 16'hFFFF};
  logic [15:0] rq0 [$];
  logic [15:0] rq1 [$];

  logic [15:0] e_dout [2];
  bit          e_valid [2];
  bit          e_busy [2];
  bit          e_err [2];
  bit          mon_on = 1'b0;

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit c, bit rd, bit wr, bit cl,
                      logic [4:0] a, logic [15:0] d);
    logic [15:0] n_dout [2];
    bit          n_valid [2];
    bit          n_err [2];
    int          la;
    logic [15:0] dd;
    rst = r; cs = c; re = rd; we = wr; clr = cl; addr = a; din = d;
    for (int s = 0; s < 2; s++) begin
      la = int'(a) & (dep[s] - 1);
      dd = d & msk[s];
      n_dout[s]  = e_dout[s];
      n_valid[s] = 1'b0;
      n_err[s]   = 1'b0;
      if (r) begin
        for (int i = 0; i < 32; i++) mm[s][i] = '0;
        left[s]   = 0;
        n_dout[s] = '0;
      end else if (left[s] > 0) begin
        mm[s][dep[s] - left[s]] = '0;
        left[s]--;
        n_err[s] = c && (rd || wr);
      end else begin
        if (c && wr) mm[s][la] = dd;
        if (c && rd) begin
          n_valid[s] = 1'b1;
          n_dout[s]  = mm[s][la];
          if (s == 0) rq0.push_back(mm[s][la]);
          else        rq1.push_back(mm[s][la]);
        end
        if (c && cl) left[s] = dep[s];
      end
    end
    @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      e_dout[s]  = n_dout[s];
      e_valid[s] = n_valid[s];
      e_err[s]   = n_err[s];
      e_busy[s]  = left[s] > 0;
    end
    #1;
  endtask

  task automatic wr(logic [4:0] a, logic [15:0] d);
    step(0, 1, 0, 1, 0, a, d);
  endtask

  task automatic rd(logic [4:0] a);
    step(0, 1, 1, 0, 0, a, 16'h0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 5'd0, 16'h0);
  endtask

  task automatic fill();
    logic [15:0] v;
    for (int i = 0; i < 32; i++) begin
      v = {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
      wr(5'(i), v);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("a_valid", {15'h0, a_valid}, {15'h0, e_valid[0]});
      check("b_valid", {15'h0, b_valid}, {15'h0, e_valid[1]});
      check("a_busy", {15'h0, a_busy}, {15'h0, e_busy[0]});
      check("b_busy", {15'h0, b_busy}, {15'h0, e_busy[1]});
      check("a_err", {15'h0, a_err}, {15'h0, e_err[0]});
      check("b_err", {15'h0, b_err}, {15'h0, e_err[1]});
      check("a_dout_hold", {8'h0, a_dout}, e_dout[0]);
      check("b_dout_hold", b_dout, e_dout[1]);
      if (a_valid) begin
        if (rq0.size() == 0) check("a_unexpected_rd", 16'h1, 16'h0);
        else check("a_rdata", {8'h0, a_dout}, rq0.pop_front());
      end
      if (b_valid) begin
        if (rq1.size() == 0) check("b_unexpected_rd", 16'h1, 16'h0);
        else check("b_rdata", b_dout, rq1.pop_front());
      end
    end
  end

  initial begin
    logic [4:0] wa;
    step(1, 0, 0, 0, 0, 5'd0, 16'h0);
    mon_on = 1'b1;
    idle();

    wr(5'd3, 16'h00A5);
    wr(5'd7, 16'h005A);
    rd(5'd3);
    rd(5'd7);
    rd(5'd0);
    idle();
    idle();

    wr(5'd2, 16'h0011);
    step(0, 1, 1, 1, 0, 5'd2, 16'h003C);
    rd(5'd2);
    idle();

    step(0, 0, 1, 1, 0, 5'd1, 16'hFFFF);
    step(0, 0, 0, 0, 1, 5'd1, 16'h0);
    rd(5'd1);
    idle();

    fill();
    step(0, 1, 0, 0, 1, 5'd0, 16'h0);
    idle();
    rd(5'd4);
    for (int i = 0; i < 34; i++) idle();
    for (int i = 0; i < 32; i++) rd(5'(i));
    idle();

    fill();
    step(0, 1, 0, 0, 1, 5'd0, 16'h0);
    idle();
    idle();
    idle();
    step(1, 0, 0, 0, 0, 5'd0, 16'h0);
    for (int i = 0; i < 32; i++) rd(5'(i));
    idle();

    wa = 5'd31;
    wr(wa, 16'hBEEF);
    wa = wa + 5'd1;
    wr(wa, 16'h1234);
    rd(5'd31);
    rd(5'd0);
    step(0, 1, 0, 0, 1, 5'd0, 16'h0);
    for (int i = 0; i < 34; i++) idle();
    rd(5'd31);

    for (int n = 0; n < 600; n++) begin
      step(($urandom % 150) == 0, ($urandom % 4) != 0,
           1'($urandom), 1'($urandom), ($urandom % 40) == 0,
           5'($urandom), 16'($urandom));
    end

    idle();
    idle();
    idle();
    check("a_queue_drained", 16'(rq0.size()), 16'h0);
    check("b_queue_drained", 16'(rq1.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
